pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program counter, instruction register and 8-level return stack that feeds `instruction_decoder`. Holds the 13-bit PC, drives the program-memory address, and latches the fetched 14-bit word into `instr_current`. It obeys the decoder's `instr_rd_en`, `instr_flush`, `pc_incr_en` and `pc_j_en` strobes, plus call/return and PCL-write strobes. Fetch is a prefetch: on every normal advance, PC already points at the word after the one being latched.

## Interface
- `STACK_DEPTH`, 8: return-stack entries; must be a power of two.
- `RESET_VECTOR`, 13'h0000: PC value after reset.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_rd_en` in 1: load `pmem_data` into the instruction register.
- `instr_flush` in 1: load NOP (14'h0000) into the instruction register.
- `pc_incr_en` in 1: PC <= PC+1.
- `pc_j_en` in 1: PC <= {`pclath`[4:3], `instr_current`[10:0]} (goto/call target).
- `stack_push` in 1: push the current PC onto the return stack (call).
- `stack_pop` in 1: PC <= top of stack; pop (return/retlw/retfie).
- `pcl_wr_en` in 1: PC <= {`pclath`[4:0], `pcl_wr_data`} (computed goto).
- `pcl_wr_data` in 8: new PCL value.
- `pclath` in 5: PCLATH register contents.
- `pmem_data` in 14: program-memory word at `pmem_addr`; asynchronous read.
- `pmem_addr` out 13: equals PC, combinational from the PC register.
- `instr_current` out 14: instruction register, to the decoder.
- `pc` out 13: PC register, for PCL reads.
- `stack_ptr` out log2(STACK_DEPTH): next free stack slot.
- `stack_ovf` out 1: sticky; sets when a push occurs with 8 entries live.

## Operation
- Reset values: PC=`RESET_VECTOR`, `instr_current`=14'h0000 (NOP), `stack_ptr`=0, live-entry count 0, `stack_ovf`=0. Stack RAM contents are not reset.
- Instruction register:
  - `instr_flush` wins over `instr_rd_en`.
  - If neither is asserted, the register holds.
  - `instr_rd_en` latches `pmem_data` addressed by the pre-update PC.
- PC source priority, one source per cycle: `pc_j_en` > `stack_pop` > `pcl_wr_en` > `pc_incr_en` > hold. Lower-priority strobes asserted in the same cycle are ignored for PC.
- Arithmetic: PC+1 wraps from 13'h1FFF to 0. The jump target uses only `instr_current`[10:0]; `pclath`[2:0] are ignored for jumps.
- Push:
  - stack[`stack_ptr`] <= PC (pre-update value); `stack_ptr` <= `stack_ptr`+1, mod depth.
  - The live count saturates at 8.
  - A push with 8 live entries overwrites the oldest entry and sets `stack_ovf`.
- Pop:
  - `stack_ptr` <= `stack_ptr`-1, mod depth; PC <= stack[`stack_ptr`-1].
  - With 0 live entries, the pop still wraps and loads whatever that slot holds (PIC-compatible). The count stays 0. No flag.
- Push and pop in the same cycle: the push is performed, the pop is ignored entirely (no PC load, no pointer change), and PC follows the remaining priority (normally `pc_j_en`).
- Call is `pc_j_en`+`stack_push` in one cycle. The pushed value is the pre-jump PC, i.e. the return address, because of prefetch.

## Timing
- All updates take effect at one rising edge. No multi-cycle state; the decoder's q_count sequencing drives the protocol.
- `pmem_addr` changes in the cycle after the PC update. `pmem_data` must be valid the same cycle (combinational ROM).
- Normal instruction, strobes at q=3 (`instr_rd_en`+`pc_incr_en`): next `instr_current`=mem[PC], PC=PC+1.
- Skip, strobes at q=3 (`instr_flush`+`pc_incr_en`): `instr_current`=NOP, PC=PC+1. The skipped word is never latched.
- Goto, strobes at q=3 (`instr_flush`+`pc_j_en`): `instr_current`=NOP, PC=target. The NOP's own q=3 then fetches mem[target] and PC becomes target+1.
- Reset mid-instruction aborts everything. The first fetch of mem[`RESET_VECTOR`] happens at the first q=3 after reset.

## Test plan
- Reset, then four `instr_rd_en`+`pc_incr_en` strobes with mem[0..3]=14'h3005,14'h0080,14'h0000,14'h2803 → `instr_current` steps through 3005, 0080, 0000, 2803; PC steps 1,2,3,4.
- `instr_current`=14'h2ABC, `pclath`=5'b11000, `pc_j_en`+`instr_flush` → PC=13'h1ABC, `instr_current`=0000; the next rd_en+incr latches mem[1ABC] and PC=1ABD.
- At PC=13'h0042, call (`pc_j_en`+`stack_push`, target 0x100), then `stack_pop` → stack[0]=0042, `stack_ptr` 0→1→0, PC ends 0042.
- Nine pushes of PC=1..9 → `stack_ovf`=1 after the ninth, `stack_ptr`=1. Eight pops return 9,8,…,2. A ninth pop (underflow) returns the slot-0 value, 9.
- Simultaneous `stack_push`+`stack_pop`+`pc_incr_en` at PC=10 → push of 10, `stack_ptr`+1, PC=11. Then `pcl_wr_en` with data 8'h20, `pclath`=5'h03 → PC=13'h0320.
- `instr_flush`+`instr_rd_en` together → `instr_current`=0000. PC=13'h1FFF with `pc_incr_en` → PC=0.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Decoder strobes, program-memory port and fetch status shared by pc_fetch_unit and its driver.
interface pc_fetch_unit_if #(
   parameter int STACK_DEPTH = 8
);
   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic             instr_rd_en;
   logic             instr_flush;
   logic             pc_incr_en;
   logic             pc_j_en;
   logic             stack_push;
   logic             stack_pop;
   logic             pcl_wr_en;
   logic [7:0]       pcl_wr_data;
   logic [4:0]       pclath;
   logic [13:0]      pmem_data;
   logic [12:0]      pmem_addr;
   logic [13:0]      instr_current;
   logic [12:0]      pc;
   logic [PTR_W-1:0] stack_ptr;
   logic             stack_ovf;

   modport master (
      output instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
             stack_push, stack_pop, pcl_wr_en, pcl_wr_data, pclath, pmem_data,
      input  pmem_addr, instr_current, pc, stack_ptr, stack_ovf
   );

   modport slave (
      input  instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
             stack_push, stack_pop, pcl_wr_en, pcl_wr_data, pclath, pmem_data,
      output pmem_addr, instr_current, pc, stack_ptr, stack_ovf
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and circular return stack feeding the instruction decoder.
// Fetch is a prefetch: PC already points past the word being latched into instr_current.
module pc_fetch_unit #(
   parameter int          STACK_DEPTH  = 8,
   parameter logic [12:0] RESET_VECTOR = 13'h0000
) (
   input  logic           clk,
   input  logic           rst,
   pc_fetch_unit_if.slave bus
);
   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   LIVE_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   LIVE_ZERO = '0;
   localparam logic [PTR_W:0]   LIVE_FULL = (PTR_W+1)'(STACK_DEPTH);

   logic [12:0]      pc_reg, pc_next;
   logic [13:0]      ir_reg, ir_next;
   logic [PTR_W-1:0] ptr_reg, ptr_next;
   logic [PTR_W:0]   live_reg, live_next;
   logic             ovf_reg, ovf_next;
   logic [12:0]      stack_mem [STACK_DEPTH];
   logic [PTR_W-1:0] ptr_dec;
   logic             pop_eff;

   // A push in the same cycle as a pop cancels the pop completely.
   assign pop_eff = bus.stack_pop & ~bus.stack_push;
   assign ptr_dec = ptr_reg - PTR_ONE;

   always_comb begin
      pc_next   = pc_reg;
      ir_next   = ir_reg;
      ptr_next  = ptr_reg;
      live_next = live_reg;
      ovf_next  = ovf_reg;

      if (bus.pc_j_en) begin
         pc_next = {bus.pclath[4:3], ir_reg[10:0]};
      end else if (pop_eff) begin
         pc_next = stack_mem[ptr_dec];
      end else if (bus.pcl_wr_en) begin
         pc_next = {bus.pclath, bus.pcl_wr_data};
      end else if (bus.pc_incr_en) begin
         pc_next = pc_reg + 13'd1;
      end

      if (bus.instr_flush) begin
         ir_next = 14'h0000;
      end else if (bus.instr_rd_en) begin
         ir_next = bus.pmem_data;
      end

      if (bus.stack_push) begin
         ptr_next = ptr_reg + PTR_ONE;
         if (live_reg == LIVE_FULL) begin
            ovf_next = 1'b1;
         end else begin
            live_next = live_reg + LIVE_ONE;
         end
      end else if (pop_eff) begin
         // Underflow still wraps the pointer, PIC style, but the live count floors at zero.
         ptr_next = ptr_dec;
         if (live_reg != LIVE_ZERO) begin
            live_next = live_reg - LIVE_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg   <= RESET_VECTOR;
         ir_reg   <= 14'h0000;
         ptr_reg  <= '0;
         live_reg <= '0;
         ovf_reg  <= 1'b0;
      end else begin
         pc_reg   <= pc_next;
         ir_reg   <= ir_next;
         ptr_reg  <= ptr_next;
         live_reg <= live_next;
         ovf_reg  <= ovf_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && bus.stack_push) begin
         stack_mem[ptr_reg] <= pc_reg;
      end
   end

   assign bus.pmem_addr     = pc_reg;
   assign bus.pc            = pc_reg;
   assign bus.instr_current = ir_reg;
   assign bus.stack_ptr     = ptr_reg;
   assign bus.stack_ovf     = ovf_reg;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed sequences then random strobes against a reference model.
module tb_pc_fetch_unit;
   localparam int D = 8;

   typedef struct packed {
      logic [12:0] pc;
      logic [13:0] ir;
      logic [2:0]  ptr;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [13:0] rom [8192];

   int checks = 0;
   int errors = 0;
   int txn    = 0;
   exp_t sb_q[$];

   // Reference model state
   logic [12:0] m_pc;
   logic [13:0] m_ir;
   logic [12:0] m_stack [D];
   int          m_ptr;
   int          m_live;
   logic        m_ovf;

   pc_fetch_unit_if #(.STACK_DEPTH(D)) bus ();

   pc_fetch_unit #(.STACK_DEPTH(D), .RESET_VECTOR(13'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.pmem_data = rom[bus.pmem_addr];

   task automatic model_step(input logic r, rd, fl, inc, j, psh, pop, pw,
                             input logic [7:0] wd, input logic [4:0] pl);
      logic [12:0] new_pc;
      logic [13:0] new_ir;
      if (r) begin
         m_pc = 13'h0000; m_ir = 14'h0000; m_ptr = 0; m_live = 0; m_ovf = 1'b0;
         return;
      end
      new_pc = m_pc;
      if (j)               new_pc = {pl[4:3], m_ir[10:0]};
      else if (pop && !psh) new_pc = m_stack[(m_ptr + D - 1) % D];
      else if (pw)         new_pc = {pl, wd};
      else if (inc)        new_pc = m_pc + 13'd1;
      new_ir = m_ir;
      if (fl)      new_ir = 14'h0000;
      else if (rd) new_ir = rom[m_pc];
      if (psh) begin
         m_stack[m_ptr] = m_pc;
         m_ptr = (m_ptr + 1) % D;
         if (m_live == D) m_ovf = 1'b1;
         else m_live = m_live + 1;
      end else if (pop) begin
         m_ptr = (m_ptr + D - 1) % D;
         if (m_live > 0) m_live = m_live - 1;
      end
      m_pc = new_pc;
      m_ir = new_ir;
   endtask

   task automatic drive(input logic r, rd, fl, inc, j, psh, pop, pw,
                        input logic [7:0] wd, input logic [4:0] pl);
      exp_t e;
      rst             = r;
      bus.instr_rd_en = rd;
      bus.instr_flush = fl;
      bus.pc_incr_en  = inc;
      bus.pc_j_en     = j;
      bus.stack_push  = psh;
      bus.stack_pop   = pop;
      bus.pcl_wr_en   = pw;
      bus.pcl_wr_data = wd;
      bus.pclath      = pl;
      model_step(r, rd, fl, inc, j, psh, pop, pw, wd, pl);
      e.pc  = m_pc;
      e.ir  = m_ir;
      e.ptr = 3'(m_ptr);
      e.ovf = m_ovf;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
      end
   endtask

   // Monitor: every edge that follows an issued transaction is compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pc",            32'(bus.pc),            32'(e.pc));
            chk("pmem_addr",     32'(bus.pmem_addr),     32'(e.pc));
            chk("instr_current", 32'(bus.instr_current), 32'(e.ir));
            chk("stack_ptr",     32'(bus.stack_ptr),     32'(e.ptr));
            chk("stack_ovf",     32'(bus.stack_ovf),     32'(e.ovf));
            $display("txn %0d pc=%h ir=%h ptr=%0d ovf=%0b", txn, bus.pc, bus.instr_current,
                     bus.stack_ptr, bus.stack_ovf);
            txn++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog txn=%0d actual=timeout required=finish", txn);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 8192; i++) rom[i] = 14'($urandom);
      rom[0] = 14'h3005; rom[1] = 14'h0080; rom[2] = 14'h0000; rom[3] = 14'h2803;
      rom[13'h0010] = 14'h2ABC;
      rom[13'h1ABC] = 14'h2100;
      for (int i = 0; i < D; i++) m_stack[i] = 13'h0000;
      m_pc = 13'h0000; m_ir = 14'h0000; m_ptr = 0; m_live = 0; m_ovf = 1'b0;

      //    r     rd    fl    inc   j     psh   pop   pw    wd     pl
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 5'h1F);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
      // Sequential fetch of mem[0..3]
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
      // Goto through IR=2ABC with pclath=11000
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 5'h00);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b11000);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
      // Call from 0x42 to 0x100, then return
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'h00);
      // Nine pushes of PC=1..9, eight pops, one underflow pop
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 5'h00);
      for (int k = 1; k <= 9; k++)
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'(k + 1), 5'h00);
      for (int k = 0; k < 9; k++)
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'h00);
      // Push+pop+incr at PC=10, then computed goto to 0x320
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 5'h03);
      // Flush beats read; PC wrap at 1FFF
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 5'h1F);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);

      // Random strobes with occasional reset
      for (int n = 0; n < 500; n++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 1) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 1) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) == 0),
               8'($urandom), 5'($urandom));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);

      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
